// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory handshake and the
// consumer-side signals of fetch_unit.
//   IMEM_REQ/IMEM_ADDR        : fetch request and address (fetch unit drives)
//   IMEM_GNT                  : acceptance of the request in the same cycle
//   IMEM_RVALID/IMEM_RDATA    : read-data beat
//   IR/IR_VALID/PC_OUT        : held instruction, its valid flag and address
//   ADVANCE                   : consumer accepts IR
//   JAL/JALR/BR_TAKEN         : next-PC selects, sampled with ADVANCE
//   JTYPE/BTYPE/ITYPE/RS1     : immediates and rs1, sampled with ADVANCE
//   REDIRECT/REDIRECT_PC      : trap/flush redirect
//   MISALIGN                  : sticky misaligned-target flag
// master = fetch unit side, slave = memory/consumer side.
interface fetch_unit_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic [31:0] IR;
    logic        IR_VALID;
    logic [31:0] PC_OUT;
    logic        ADVANCE;
    logic        JAL;
    logic        JALR;
    logic        BR_TAKEN;
    logic [31:0] JTYPE;
    logic [31:0] BTYPE;
    logic [31:0] ITYPE;
    logic [31:0] RS1;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        MISALIGN;

    modport master (
        output IMEM_REQ, IMEM_ADDR, IR, IR_VALID, PC_OUT, MISALIGN,
        input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, ADVANCE, JAL, JALR,
               BR_TAKEN, JTYPE, BTYPE, ITYPE, RS1, REDIRECT, REDIRECT_PC
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR, IR, IR_VALID, PC_OUT, MISALIGN,
        output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, ADVANCE, JAL, JALR,
               BR_TAKEN, JTYPE, BTYPE, ITYPE, RS1, REDIRECT, REDIRECT_PC
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a one-entry
// instruction register, next-PC selection and redirect/flush handling.
// Ports:
//   CLK    : clock, all state updates on rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : fetch_unit_if.master (memory handshake + consumer signals)
// Parameter RESET_VEC is the PC loaded on reset.
module fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST_N,
    fetch_unit_if.master bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_e;

    state_e      state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_out_q,   pc_out_d;
    logic [31:0] ir_q,       ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        misalign_q, misalign_d;
    logic        discard_q,  discard_d;
    logic        started_q,  started_d;

    logic        imem_req;
    logic        gnt_fire;
    logic [31:0] next_pc;

    // started_q keeps the request low until the first edge after reset release.
    // discard_q blocks the new request while a stale response is still owed.
    assign imem_req = started_q && (state_q == S_REQ) && !discard_q;
    assign gnt_fire = imem_req && bus.IMEM_GNT;

    assign bus.IMEM_REQ  = imem_req;
    assign bus.IMEM_ADDR = fetch_pc_q;
    assign bus.IR        = ir_q;
    assign bus.IR_VALID  = ir_valid_q;
    assign bus.PC_OUT    = pc_out_q;
    assign bus.MISALIGN  = misalign_q;

    always_comb begin
        next_pc = pc_out_q + 32'd4;
        if (bus.JALR) begin
            next_pc = (bus.RS1 + bus.ITYPE) & 32'hFFFF_FFFE;
        end else if (bus.JAL) begin
            next_pc = pc_out_q + bus.JTYPE;
        end else if (bus.BR_TAKEN) begin
            next_pc = pc_out_q + bus.BTYPE;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_out_d   = pc_out_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        misalign_d = misalign_q;
        discard_d  = discard_q;
        started_d  = 1'b1;

        if (bus.REDIRECT && (state_q != S_ERR)) begin
            ir_valid_d = 1'b0;
            // A response is still owed if one was already pending and does not
            // arrive this cycle, or if a grant is being accepted right now.
            discard_d  = (discard_q && !bus.IMEM_RVALID)
                       || ((state_q == S_WAIT) && !bus.IMEM_RVALID)
                       || gnt_fire;
            fetch_pc_d = bus.REDIRECT_PC;
            if (bus.REDIRECT_PC[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_ERR;
            end else begin
                state_d    = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (discard_q && bus.IMEM_RVALID) begin
                        discard_d = 1'b0;
                    end
                    if (gnt_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.IMEM_RVALID) begin
                        ir_d       = bus.IMEM_RDATA;
                        pc_out_d   = fetch_pc_q;
                        ir_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.ADVANCE) begin
                        ir_valid_d = 1'b0;
                        fetch_pc_d = next_pc;
                        if (next_pc[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                            state_d    = S_ERR;
                        end else begin
                            state_d    = S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    ir_valid_d = 1'b0;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_VEC;
            pc_out_q   <= RESET_VEC;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            discard_q  <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_out_q   <= pc_out_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            misalign_q <= misalign_d;
            discard_q  <= discard_d;
            started_q  <= started_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by a randomized run of
// fetch_unit against a transaction-level model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_VEC(RV)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // model state
    logic [31:0] m_fetch, m_ir, m_pc;
    logic        m_valid, m_err;
    // memory-side state: at most one outstanding grant
    logic        mem_busy, mem_drop, mem_rst;
    logic [31:0] mem_addr, mem_word;
    int          mem_delay;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        bus.IMEM_RDATA  = '0;
        bus.ADVANCE     = 1'b0;
        bus.JAL         = 1'b0;
        bus.JALR        = 1'b0;
        bus.BR_TAKEN    = 1'b0;
        bus.JTYPE       = '0;
        bus.BTYPE       = '0;
        bus.ITYPE       = '0;
        bus.RS1         = '0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},      bus.IMEM_REQ, 0);
        check({tag, "_valid"},    bus.IR_VALID, 0);
        check({tag, "_ir"},       bus.IR,       32'h0000_0013);
        check({tag, "_pc_out"},   bus.PC_OUT,   RV);
        check({tag, "_misalign"}, bus.MISALIGN, 0);
        check({tag, "_addr"},     bus.IMEM_ADDR, RV);
    endtask

    // called just after a negedge; returns just after a negedge
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_req", bus.IMEM_REQ, 0);
    endtask

    // zero-wait fetch of one word at an expected address
    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word);
        int n = 0;
        while (!bus.IMEM_REQ && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("serve_req", bus.IMEM_REQ, 1);
        check("serve_addr", bus.IMEM_ADDR, exp_addr);
        bus.IMEM_GNT = 1'b1;
        @(negedge clk);
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = word;
        @(negedge clk);
        bus.IMEM_RVALID = 1'b0;
        check("serve_valid", bus.IR_VALID, 1);
        check("serve_ir", bus.IR, word);
        check("serve_pc_out", bus.PC_OUT, exp_addr);
    endtask

    function automatic logic [31:0] rnd_word(input int low_mask_bits);
        logic [31:0] v;
        v = $urandom;
        if (($urandom % 10) != 0) begin
            v = v & ~low_mask_bits;
        end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] held_ir;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        #1 check("por_release_req", bus.IMEM_REQ, 0);
        @(negedge clk);

        // first fetch with zero-wait memory
        check("d1_req", bus.IMEM_REQ, 1);
        check("d1_addr", bus.IMEM_ADDR, 32'h0);
        bus.IMEM_GNT = 1'b1;
        @(negedge clk);
        bus.IMEM_GNT = 1'b0;
        check("d1_req_in_wait", bus.IMEM_REQ, 0);
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'h0050_0093;
        @(negedge clk);
        bus.IMEM_RVALID = 1'b0;
        check("d1_valid", bus.IR_VALID, 1);
        check("d1_ir", bus.IR, 32'h0050_0093);
        check("d1_pc_out", bus.PC_OUT, 32'h0);

        // hold without ADVANCE, with noise on RVALID
        held_ir = bus.IR;
        for (int i = 0; i < 10; i++) begin
            bus.IMEM_RVALID = i[0];
            bus.IMEM_RDATA  = 32'hBAD0_0000 + i;
            @(negedge clk);
            check("d2_hold_ir", bus.IR, held_ir);
            check("d2_hold_valid", bus.IR_VALID, 1);
        end
        bus.IMEM_RVALID = 1'b0;

        // taken branch with negative offset
        bus.REDIRECT = 1'b1;
        bus.REDIRECT_PC = 32'h100;
        @(negedge clk);
        bus.REDIRECT = 1'b0;
        check("d3_redirect_clears_valid", bus.IR_VALID, 0);
        serve(32'h100, 32'h0000_0113);
        bus.ADVANCE = 1'b1; bus.BR_TAKEN = 1'b1; bus.BTYPE = 32'hFFFF_FFF0;
        @(negedge clk);
        idle_inputs();
        check("d3_adv_clears_valid", bus.IR_VALID, 0);
        for (int i = 0; i < 5; i++) begin
            check("d3_stall_req", bus.IMEM_REQ, 1);
            check("d3_stall_addr", bus.IMEM_ADDR, 32'hF0);
            @(negedge clk);
        end
        serve(32'hF0, 32'h0000_0213);

        // JAL over BR_TAKEN
        bus.REDIRECT = 1'b1;
        bus.REDIRECT_PC = 32'h100;
        @(negedge clk);
        bus.REDIRECT = 1'b0;
        serve(32'h100, 32'h0000_0313);
        bus.ADVANCE = 1'b1; bus.BR_TAKEN = 1'b1; bus.BTYPE = 32'hFFFF_FFF0;
        bus.JAL = 1'b1; bus.JTYPE = 32'h20;
        @(negedge clk);
        idle_inputs();
        check("d3_jal_req", bus.IMEM_REQ, 1);
        check("d3_jal_addr", bus.IMEM_ADDR, 32'h120);

        // redirect while waiting: stale word dropped
        bus.IMEM_GNT = 1'b1;
        @(negedge clk);
        bus.IMEM_GNT = 1'b0;
        bus.REDIRECT = 1'b1;
        bus.REDIRECT_PC = 32'h80;
        @(negedge clk);
        bus.REDIRECT = 1'b0;
        check("d4_req_blocked", bus.IMEM_REQ, 0);
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.IMEM_RVALID = 1'b0;
        check("d4_dropped_valid", bus.IR_VALID, 0);
        check("d4_req", bus.IMEM_REQ, 1);
        check("d4_addr", bus.IMEM_ADDR, 32'h80);

        // reset mid-transaction
        bus.IMEM_GNT = 1'b1;
        @(negedge clk);
        bus.IMEM_GNT = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("d5");
        @(negedge clk);
        rst_n = 1'b1;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hCAFE_F00D;
        @(negedge clk);
        check("d5_stale_valid", bus.IR_VALID, 0);
        check("d5_req", bus.IMEM_REQ, 1);
        check("d5_addr", bus.IMEM_ADDR, RV);
        @(negedge clk);
        bus.IMEM_RVALID = 1'b0;
        check("d5_stale2_valid", bus.IR_VALID, 0);
        serve(RV, 32'h0000_0013);

        // misaligned JALR target halts
        bus.ADVANCE = 1'b1; bus.JALR = 1'b1; bus.RS1 = 32'h1003; bus.ITYPE = 32'h0;
        @(negedge clk);
        idle_inputs();
        check("d6_misalign", bus.MISALIGN, 1);
        check("d6_req", bus.IMEM_REQ, 0);
        check("d6_valid", bus.IR_VALID, 0);
        bus.IMEM_GNT = 1'b1; bus.IMEM_RVALID = 1'b1;
        bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h40;
        @(negedge clk);
        idle_inputs();
        check("d6_err_misalign", bus.MISALIGN, 1);
        check("d6_err_req", bus.IMEM_REQ, 0);
        check("d6_err_valid", bus.IR_VALID, 0);

        // randomized run against the model
        do_reset();
        m_fetch = RV; m_valid = 1'b0; m_err = 1'b0; m_ir = '0; m_pc = RV;
        mem_busy = 1'b0; mem_drop = 1'b0; mem_rst = 1'b0;
        mem_addr = '0; mem_word = '0; mem_delay = 0;
        begin
            int err_cycles = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                logic        exp_req, redir, adv, gnt, deliver, spurious, old_valid;
                logic        jal, jalr, br;
                logic [31:0] target, jt, bt, it, rs1, nxt;
                @(negedge clk);
                idle_inputs();
                if ((($urandom % 200) == 0) || (err_cycles > 12)) begin
                    do_reset();
                    m_fetch = RV; m_valid = 1'b0; m_err = 1'b0; err_cycles = 0;
                    if (mem_busy) begin
                        mem_drop = 1'b1;
                        mem_rst  = 1'b1;
                    end
                    continue;
                end

                exp_req = !m_err && !m_valid && (!mem_busy || mem_rst);
                check("r_req", bus.IMEM_REQ, exp_req);
                if (exp_req) check("r_addr", bus.IMEM_ADDR, m_fetch);
                check("r_valid", bus.IR_VALID, m_valid);
                if (m_valid) begin
                    check("r_ir", bus.IR, m_ir);
                    check("r_pc_out", bus.PC_OUT, m_pc);
                end
                check("r_misalign", bus.MISALIGN, m_err);
                if (m_err) err_cycles++;

                redir  = ($urandom % 16) == 0;
                target = rnd_word(3);
                adv    = ($urandom % 3) == 0;
                jal    = ($urandom % 4) == 0;
                jalr   = ($urandom % 4) == 0;
                br     = ($urandom % 4) == 0;
                jt     = rnd_word(3);
                bt     = rnd_word(3);
                it     = rnd_word(3);
                rs1    = rnd_word(2);
                gnt      = bus.IMEM_REQ && !mem_busy && (($urandom % 2) == 0);
                deliver  = mem_busy && (mem_delay == 0);
                spurious = !mem_busy && (($urandom % 8) == 0);
                if (mem_busy && !deliver) mem_delay--;

                bus.REDIRECT    = redir;
                bus.REDIRECT_PC = target;
                bus.ADVANCE     = adv;
                bus.JAL         = jal;
                bus.JALR        = jalr;
                bus.BR_TAKEN    = br;
                bus.JTYPE       = jt;
                bus.BTYPE       = bt;
                bus.ITYPE       = it;
                bus.RS1         = rs1;
                bus.IMEM_GNT    = gnt;
                bus.IMEM_RVALID = deliver || spurious;
                bus.IMEM_RDATA  = deliver ? mem_word : 32'($urandom);

                old_valid = m_valid;
                if (deliver) begin
                    if (!mem_drop && !redir) begin
                        m_valid = 1'b1;
                        m_ir    = mem_word;
                        m_pc    = mem_addr;
                    end
                    mem_busy = 1'b0;
                    mem_drop = 1'b0;
                    mem_rst  = 1'b0;
                end
                if (gnt) begin
                    mem_busy  = 1'b1;
                    mem_addr  = m_fetch;
                    mem_word  = $urandom;
                    mem_delay = int'($urandom % 4);
                    mem_drop  = 1'b0;
                    mem_rst   = 1'b0;
                end
                if (!m_err) begin
                    if (redir) begin
                        m_valid = 1'b0;
                        if (mem_busy) mem_drop = 1'b1;
                        if (target[1:0] != 2'b00) m_err = 1'b1;
                        else m_fetch = target;
                    end else if (adv && old_valid) begin
                        if (jalr)     nxt = (rs1 + it) & 32'hFFFF_FFFE;
                        else if (jal) nxt = m_pc + jt;
                        else if (br)  nxt = m_pc + bt;
                        else          nxt = m_pc + 32'd4;
                        m_valid = 1'b0;
                        if (nxt[1:0] != 2'b00) m_err = 1'b1;
                        else m_fetch = nxt;
                    end
                end
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Port CLK, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-003 Port RST_N, input, 1, is the reset: asynchronous, active-low.
REQ-004 Port IMEM_REQ, output, 1, is the fetch request to instruction memory.
REQ-005 Port IMEM_ADDR, output, 32, is the fetch address, valid while IMEM_REQ=1.
REQ-006 Port IMEM_GNT, input, 1, is memory acceptance of the request in the same cycle.
REQ-007 Port IMEM_RVALID, input, 1, marks a read-data beat.
REQ-008 Port IMEM_RDATA, input, 32, carries the instruction word.
REQ-009 Port IR, output, 32, is the held instruction; IR[31:7] drives the immediate generator.
REQ-010 Port IR_VALID, output, 1, is high while IR holds an unconsumed instruction.
REQ-011 Port PC_OUT, output, 32, is the address of the instruction in IR.
REQ-012 Port ADVANCE, input, 1, is the consumer's acceptance of IR, meaningful only when IR_VALID=1.
REQ-013 Ports JAL, JALR, BR_TAKEN, input, 1 each, are next-PC selects sampled with ADVANCE.
REQ-014 Ports JTYPE, BTYPE, ITYPE, RS1, input, 32 each, are the immediates and rs1 value sampled with ADVANCE.
REQ-015 Ports REDIRECT, input, 1, and REDIRECT_PC, input, 32, form the trap/flush redirect.
REQ-016 Port MISALIGN, output, 1, is the sticky misaligned-target flag.

Function
REQ-017 States SHALL be REQ (IMEM_REQ=1), WAIT (response pending), HOLD (IR_VALID=1), and ERR (halted).
REQ-018 In REQ, IMEM_ADDR SHALL equal the internal fetch PC, held stable until IMEM_GNT=1; on GNT the block SHALL move to WAIT.
REQ-019 At most one request SHALL be outstanding; IMEM_REQ SHALL be 0 outside REQ.
REQ-020 In WAIT with IMEM_RVALID=1 and no discard pending, the block SHALL latch IR<=IMEM_RDATA and PC_OUT<=fetch PC, set IR_VALID=1, and move to HOLD.
REQ-021 In HOLD with ADVANCE=0, IR, PC_OUT and IR_VALID SHALL hold unchanged.
REQ-022 In HOLD with ADVANCE=1, the next PC SHALL be selected by priority: JALR gives (RS1+ITYPE)&~1; else JAL gives PC_OUT+JTYPE; else BR_TAKEN gives PC_OUT+BTYPE; else PC_OUT+4.
REQ-023 Next-PC additions SHALL be 32-bit modulo, so wrap-around past 32'hFFFF_FFFC is allowed silently.
REQ-024 On ADVANCE, IR_VALID SHALL clear on the next edge and the state SHALL move to REQ.
REQ-025 If the selected next PC has bits[1:0]!=0, the block SHALL instead set MISALIGN=1 and enter ERR, issuing no request.
REQ-026 ERR SHALL be left only by reset; while in ERR, IR_VALID=0 and IMEM_REQ=0.
REQ-027 REDIRECT=1 in any state except ERR SHALL load the fetch PC with REDIRECT_PC, clear IR_VALID, and move to REQ.
REQ-028 REDIRECT=1 SHALL take priority over ADVANCE in the same cycle.
REQ-029 A REDIRECT in REQ SHALL cause the new address to be driven next cycle, even if GNT=1 on the redirect cycle.
REQ-030 A REDIRECT in WAIT, or in REQ with GNT=1, SHALL set a discard flag so that the old response, when its RVALID arrives, is dropped and clears the flag.
REQ-031 While the discard flag is set, the new request SHALL NOT be issued until the old response has been dropped.
REQ-032 A misaligned REDIRECT_PC SHALL follow the same rule as REQ-025.
REQ-033 IMEM_RVALID outside WAIT or discard SHALL be ignored.
REQ-034 Best-case latency with zero-wait memory (GNT in REQ, RVALID next cycle) SHALL be 2 cycles from entering REQ to IR_VALID=1.

Reset
REQ-035 RST_N=0 SHALL immediately force: state REQ-pending, fetch PC=RESET_VEC, PC_OUT=RESET_VEC, IR=32'h0000_0013 (nop), IR_VALID=0, IMEM_REQ=0, MISALIGN=0, discard flag=0.
REQ-036 IMEM_REQ SHALL first assert in the first cycle after RST_N rises.
REQ-037 Reset asserted mid-transaction SHALL abandon it; any later RVALID SHALL be ignored until a new grant occurs.

Verification
REQ-038 Reset release, zero-wait memory returning 32'h00500093 at address 0 -> IMEM_ADDR=0, then IR=32'h00500093, PC_OUT=0, IR_VALID=1 two cycles after the grant.
REQ-039 IR_VALID with PC_OUT=0x100, ADVANCE=1, BR_TAKEN=1, BTYPE=32'hFFFF_FFF0 -> next IMEM_ADDR=0xF0; with JAL=1 also set, JTYPE=0x20 -> 0x120.
REQ-040 ADVANCE=1, JALR=1, RS1=0x1003, ITYPE=0 -> fetch address 0x1002, MISALIGN=1, ERR, IMEM_REQ stays 0.
REQ-041 REDIRECT to 0x80 in WAIT, then old RVALID with 32'hDEADBEEF -> word dropped, IR_VALID stays 0, next IMEM_ADDR=0x80.
REQ-042 GNT withheld for 5 cycles -> IMEM_REQ and IMEM_ADDR held stable throughout; ADVANCE=0 in HOLD for 10 cycles -> IR unchanged.
REQ-043 RST_N pulled low in WAIT -> outputs take reset values asynchronously, a stale RVALID is ignored, and the first fetch is RESET_VEC.
